// File: rtl/crc_mem_pkg.sv
// Shared types and constants for the CRC memory self-test initiator.
package crc_mem_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int ERR_CNT_W  = 6;

    // Burst code n means n+1 adjacent bits are flipped by the memory's fault injector.
    typedef enum logic [1:0] {
        BURST_1 = 2'd0,
        BURST_2 = 2'd1,
        BURST_3 = 2'd2,
        BURST_4 = 2'd3
    } burst_len_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ISSUE,
        ST_WR_WAIT,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_NEXT,
        ST_FINISH
    } bist_state_t;

endpackage

// File: rtl/crc_mem_bist_if.sv
// Command/response bus between the self-test initiator and the CRC-protected memory.
interface crc_mem_bist_if
    import crc_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] fault_addr;
    logic [1:0]        burst_len;
    logic              fault_enable;
    logic              write_busy;
    logic              read_busy;
    logic              data_valid;
    logic              error_detected;
    logic              completed;
    logic [DATA_W-1:0] rdata;

    modport master (
        output write, read, addr, wdata, fault_addr, burst_len, fault_enable,
        input  write_busy, read_busy, data_valid, error_detected, completed, rdata
    );

    modport slave (
        input  write, read, addr, wdata, fault_addr, burst_len, fault_enable,
        output write_busy, read_busy, data_valid, error_detected, completed, rdata
    );
endinterface

// File: rtl/crc_bist_timeout.sv
// Command watchdog: loads TIMEOUT-1 on clear, counts down while enabled, expires at zero.
module crc_bist_timeout #(
    parameter int TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expire
);
    localparam int             CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= LOAD_VAL;
        end else if (count_en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expire = (count == '0);
endmodule

// File: rtl/crc_mem_bist.sv
// Two-pass write/read-back self test of the CRC-protected memory.
// Optional read-side fault injection is enabled by defining CRC_BIST_FAULT_INJ_EN.
//
// state     | meaning
// IDLE      | waiting for start, results held
// WR_ISSUE  | waiting for memory idle, then strobe a write
// WR_WAIT   | waiting for write completion
// RD_ISSUE  | waiting for memory idle, then strobe a read
// RD_WAIT   | waiting for read completion, check result
// NEXT      | advance address or pass after a read
// FINISH    | pulse done, publish pass
module crc_mem_bist
    import crc_mem_pkg::*;
#(
    parameter int              ADDR_W  = ADDR_W_DEF,
    parameter int              DATA_W  = DATA_W_DEF,
    parameter logic [DATA_W-1:0] SEED  = DATA_W'(8'h5A),
    parameter int              TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    inj_fault_addr,
    input  logic [1:0]           inj_burst_len,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    first_fail_addr,
    output logic                 first_fail_pass,
    output logic                 timeout_err,
    crc_mem_bist_if.master       mem
);
    localparam logic [ADDR_W-1:0]    ADDR_MAX    = '1;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    bist_state_t       state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic              pass_idx;
    logic [DATA_W-1:0] exp_word;
    logic              mem_idle, issue_wr, issue_rd, in_wait, rd_fail, to_expire;
    logic              mem_write_q, mem_read_q, fault_en_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    // Pass 1 uses the bitwise inverse of the pass-0 pattern.
    assign exp_word = (DATA_W'(addr) ^ SEED) ^ {DATA_W{pass_idx}};
    assign mem_idle = ~mem.write_busy & ~mem.read_busy;
    assign issue_wr = (state == ST_WR_ISSUE) && mem_idle;
    assign issue_rd = (state == ST_RD_ISSUE) && mem_idle;
    assign in_wait  = (state == ST_WR_WAIT) || (state == ST_RD_WAIT);
    assign rd_fail  = mem.error_detected | ~mem.data_valid | (mem.rdata != exp_word);

    crc_bist_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (issue_wr | issue_rd),
        .count_en (in_wait & ~mem.completed),
        .expire   (to_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start) state_nxt = ST_WR_ISSUE;
            ST_WR_ISSUE: if (mem_idle) state_nxt = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (mem.completed) state_nxt = (addr == ADDR_MAX) ? ST_RD_ISSUE : ST_WR_ISSUE;
                else if (to_expire) state_nxt = ST_FINISH;
            end
            ST_RD_ISSUE: if (mem_idle) state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (mem.completed) state_nxt = ST_NEXT;
                else if (to_expire) state_nxt = ST_FINISH;
            end
            ST_NEXT: begin
                if (addr != ADDR_MAX) state_nxt = ST_RD_ISSUE;
                else if (!pass_idx)   state_nxt = ST_WR_ISSUE;
                else                  state_nxt = ST_FINISH;
            end
            ST_FINISH:   state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_IDLE:   ;
            ST_FINISH: done = 1'b1;
            default:   busy = 1'b1;
        endcase
    end

`ifdef CRC_BIST_FAULT_INJ_EN
    localparam logic RD_FAULT_EN = 1'b1;
    logic [ADDR_W-1:0] inj_addr_q;
    burst_len_t        inj_burst_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_addr_q  <= '0;
            inj_burst_q <= BURST_1;
        end else if ((state == ST_IDLE) && start) begin
            inj_addr_q  <= inj_fault_addr;
            inj_burst_q <= burst_len_t'(inj_burst_len);
        end
    end

    assign mem.fault_addr = inj_addr_q;
    assign mem.burst_len  = inj_burst_q;
`else
    localparam logic RD_FAULT_EN = 1'b0;
    logic unused_inj;

    assign unused_inj     = ^{inj_fault_addr, inj_burst_len};
    assign mem.fault_addr = '0;
    assign mem.burst_len  = BURST_1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr            <= '0;
            pass_idx        <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
            first_fail_pass <= 1'b0;
            timeout_err     <= 1'b0;
            pass            <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_read_q      <= 1'b0;
            fault_en_q      <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
        end else begin
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    err_count       <= '0;
                    first_fail_addr <= '0;
                    first_fail_pass <= 1'b0;
                    timeout_err     <= 1'b0;
                    pass            <= 1'b0;
                    addr            <= '0;
                    pass_idx        <= 1'b0;
                end
                ST_WR_ISSUE: if (mem_idle) begin
                    mem_write_q <= 1'b1;
                    mem_addr_q  <= addr;
                    mem_wdata_q <= exp_word;
                    fault_en_q  <= 1'b0;
                end
                ST_WR_WAIT: begin
                    if (mem.completed)  addr <= (addr == ADDR_MAX) ? '0 : addr + ADDR_W'(1);
                    else if (to_expire) timeout_err <= 1'b1;
                end
                ST_RD_ISSUE: if (mem_idle) begin
                    mem_read_q <= 1'b1;
                    mem_addr_q <= addr;
                    fault_en_q <= RD_FAULT_EN;
                end
                ST_RD_WAIT: begin
                    if (mem.completed) begin
                        if (rd_fail) begin
                            // err_count is still zero only for the very first failing read
                            if (err_count == '0) begin
                                first_fail_addr <= addr;
                                first_fail_pass <= pass_idx;
                            end
                            if (err_count != ERR_CNT_MAX) err_count <= err_count + ERR_CNT_W'(1);
                        end
                    end else if (to_expire) begin
                        timeout_err <= 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (addr != ADDR_MAX) begin
                        addr <= addr + ADDR_W'(1);
                    end else if (!pass_idx) begin
                        pass_idx <= 1'b1;
                        addr     <= '0;
                    end
                end
                ST_FINISH: begin
                    pass       <= (err_count == '0) && !timeout_err;
                    fault_en_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mem.write        = mem_write_q;
    assign mem.read         = mem_read_q;
    assign mem.addr         = mem_addr_q;
    assign mem.wdata        = mem_wdata_q;
    assign mem.fault_enable = fault_en_q;
endmodule

// File: tb/tb_crc_mem_bist.sv
// Self-checking bench for crc_mem_bist: behavioural memory with selectable faults and a per-strobe scoreboard.
module tb_crc_mem_bist;
    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int TO  = 32;
    localparam int LAT = 13;
`ifdef CRC_BIST_FAULT_INJ_EN
    localparam bit FAULT_BUILD = 1'b1;
`else
    localparam bit FAULT_BUILD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] inj_fault_addr = '0;
    logic [1:0]    inj_burst_len = '0;
    logic          busy, done, pass, first_fail_pass, timeout_err;
    logic [5:0]    err_count;
    logic [AW-1:0] first_fail_addr;

    crc_mem_bist_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

    crc_mem_bist #(.ADDR_W(AW), .DATA_W(DW), .SEED(8'h5A), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .inj_fault_addr  (inj_fault_addr),
        .inj_burst_len   (inj_burst_len),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_fail_addr (first_fail_addr),
        .first_fail_pass (first_fail_pass),
        .timeout_err     (timeout_err),
        .mem             (mem_bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // mode 0: healthy, 1: address 9 corrupted on pass 1, 2: 5th write never completes
    int mode = 0;
    int test_id = 0;

    // ---------------- memory model ----------------
    int          m_test = -1;
    int          pend, wr_n, rd_n, m_err, m_first_addr, m_first_pass;
    int          ma, mp;
    logic        pend_rd, pend_err, me;
    logic [7:0]  pend_data, md, mexp, mask;
    logic [7:0]  mem_arr [16];

    always @(negedge clk) begin
        if (m_test != test_id) begin
            m_test = test_id;
            pend = 0; wr_n = 0; rd_n = 0;
            m_err = 0; m_first_addr = 0; m_first_pass = 0;
            pend_rd = 1'b0; pend_err = 1'b0; pend_data = '0;
            for (int i = 0; i < 16; i++) mem_arr[i] = '0;
            mem_bus.write_busy     = 1'b0;
            mem_bus.read_busy      = 1'b0;
            mem_bus.completed      = 1'b0;
            mem_bus.data_valid     = 1'b0;
            mem_bus.error_detected = 1'b0;
            mem_bus.rdata          = '0;
        end else begin
            mem_bus.completed = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_bus.completed  = 1'b1;
                    mem_bus.write_busy = 1'b0;
                    mem_bus.read_busy  = 1'b0;
                    if (pend_rd) begin
                        mem_bus.rdata          = pend_data;
                        mem_bus.error_detected = pend_err;
                        mem_bus.data_valid     = 1'b1;
                    end
                end
            end
            if (mem_bus.write) begin
                wr_n++;
                if (!(mode == 2 && wr_n == 5)) begin
                    mem_arr[mem_bus.addr] = mem_bus.wdata;
                    pend = LAT - 1;
                    pend_rd = 1'b0;
                    mem_bus.write_busy = 1'b1;
                end
            end
            if (mem_bus.read) begin
                ma = int'(mem_bus.addr);
                mp = rd_n / 16;
                rd_n++;
                md = mem_arr[ma];
                me = mem_bus.fault_enable;
                if (me) begin
                    mask = '0;
                    for (int b = 0; b <= int'(mem_bus.burst_len); b++)
                        mask[(int'(mem_bus.fault_addr) + b) % 8] = 1'b1;
                    md = md ^ mask;
                end
                if (mode == 1 && mp == 1 && ma == 9) md = md ^ 8'h01;
                mexp = 8'(ma) ^ 8'h5A ^ ((mp == 1) ? 8'hFF : 8'h00);
                if (me || md != mexp) begin
                    if (m_err == 0) begin
                        m_first_addr = ma;
                        m_first_pass = mp;
                    end
                    m_err++;
                end
                pend_rd = 1'b1; pend_data = md; pend_err = me;
                pend = LAT - 1;
                mem_bus.read_busy = 1'b1;
            end
        end
    end

    // ---------------- compare process ----------------
    int         c_test = -1;
    int         op_idx, ca, cp;
    logic       prev_strobe;
    logic [7:0] cexp, wd_p0, wd_p1;

    always @(negedge clk) begin
        if (c_test != test_id) begin
            c_test = test_id;
            op_idx = 0;
            prev_strobe = 1'b0;
            wd_p0 = '0;
            wd_p1 = '0;
        end else if (rst_n) begin
            if (mem_bus.write || mem_bus.read) begin
                check("strobe_width", 32'(prev_strobe), 0);
                ca = op_idx % 16;
                cp = op_idx / 32;
                cexp = 8'(ca) ^ 8'h5A ^ ((cp == 1) ? 8'hFF : 8'h00);
                check("op_is_read", 32'(mem_bus.read), 32'((op_idx / 16) % 2));
                check("op_addr", 32'(mem_bus.addr), 32'(ca));
                check("fault_en", 32'(mem_bus.fault_enable), 32'(mem_bus.read & FAULT_BUILD));
                if (mem_bus.write) begin
                    check("wdata", 32'(mem_bus.wdata), 32'(cexp));
                    if (op_idx == 0)  wd_p0 = mem_bus.wdata;
                    if (op_idx == 32) wd_p1 = mem_bus.wdata;
                end
`ifdef CRC_BIST_FAULT_INJ_EN
                if (mem_bus.read) begin
                    check("fault_addr", 32'(mem_bus.fault_addr), 32'(inj_fault_addr));
                    check("burst_len", 32'(mem_bus.burst_len), 32'(inj_burst_len));
                end
`else
                check("fault_addr_tied", 32'(mem_bus.fault_addr), 0);
                check("burst_len_tied", 32'(mem_bus.burst_len), 0);
`endif
                op_idx++;
            end
            prev_strobe = mem_bus.write | mem_bus.read;
            if (done) begin
                check("done_busy", 32'(busy), 0);
                check("err_count", 32'(err_count), 32'((m_err > 63) ? 63 : m_err));
                check("first_fail_addr", 32'(first_fail_addr), 32'(m_first_addr));
                check("first_fail_pass", 32'(first_fail_pass), 32'(m_first_pass));
                check("timeout_err", 32'(timeout_err), 32'(mode == 2));
                check("op_total", 32'(op_idx), 32'((mode == 2) ? 5 : 64));
            end
        end
    end

    // ---------------- directed sequences ----------------
    int done_cyc, strobe_cyc, n_wr;
    bit found;

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_pass"}, 32'(pass), 0);
        check({tag, "_timeout"}, 32'(timeout_err), 0);
        check({tag, "_err"}, 32'(err_count), 0);
        check({tag, "_ffaddr"}, 32'(first_fail_addr), 0);
        check({tag, "_ffpass"}, 32'(first_fail_pass), 0);
        check({tag, "_write"}, 32'(mem_bus.write), 0);
        check({tag, "_read"}, 32'(mem_bus.read), 0);
        check({tag, "_addr"}, 32'(mem_bus.addr), 0);
        check({tag, "_wdata"}, 32'(mem_bus.wdata), 0);
        check({tag, "_fault_addr"}, 32'(mem_bus.fault_addr), 0);
        check({tag, "_burst"}, 32'(mem_bus.burst_len), 0);
        check({tag, "_fault_en"}, 32'(mem_bus.fault_enable), 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int at_cyc);
        at_cyc = -1;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (done) begin
                at_cyc = cyc;
                break;
            end
        end
        if (at_cyc < 0) check("done_seen", 32'(done), 1);
    endtask

    task automatic run_test(input int m, input logic [AW-1:0] fa, input logic [1:0] bl,
                            input logic exp_pass);
        mode = m;
        inj_fault_addr = fa;
        inj_burst_len = bl;
        test_id++;
        @(negedge clk);
        pulse_start();
        check("busy_rise", 32'(busy), 1);
        check("pass_cleared", 32'(pass), 0);
        wait_done(4000, done_cyc);
        @(negedge clk);
        check("pass", 32'(pass), 32'(exp_pass));
        check("busy_fall", 32'(busy), 0);
    endtask

    initial begin
        #12;
        check_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef CRC_BIST_FAULT_INJ_EN
        run_test(0, 4'd3, 2'd0, 1'b0);
        check("inj1_err", 32'(err_count), 32);
        check("inj1_ffaddr", 32'(first_fail_addr), 0);
        check("inj1_ffpass", 32'(first_fail_pass), 0);

        run_test(0, 4'd4, 2'd3, 1'b0);
        check("inj4_err", 32'(err_count), 32);
        check("inj4_timeout", 32'(timeout_err), 0);
`else
        run_test(0, '0, '0, 1'b1);
        check("healthy_err", 32'(err_count), 0);
        check("healthy_timeout", 32'(timeout_err), 0);
        check("healthy_wd_p0", 32'(wd_p0), 32'h5A);
        check("healthy_wd_p1", 32'(wd_p1), 32'hA5);

        run_test(1, '0, '0, 1'b0);
        check("corrupt_err", 32'(err_count), 1);
        check("corrupt_ffaddr", 32'(first_fail_addr), 9);
        check("corrupt_ffpass", 32'(first_fail_pass), 1);
`endif

        // memory hangs on the 5th write; a start mid-test must be ignored
        mode = 2;
        test_id++;
        @(negedge clk);
        pulse_start();
        n_wr = 0;
        strobe_cyc = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (mem_bus.write) n_wr++;
            if (n_wr == 5) begin
                strobe_cyc = cyc;
                break;
            end
        end
        check("hang_write_seen", 32'(n_wr), 5);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ignored_busy", 32'(busy), 1);
        wait_done(200, done_cyc);
        check("timeout_latency", 32'(done_cyc - strobe_cyc), 32);
        @(negedge clk);
        check("timeout_flag", 32'(timeout_err), 1);
        check("timeout_pass", 32'(pass), 0);

`ifndef CRC_BIST_FAULT_INJ_EN
        // asynchronous abort on the read strobe of address 5, then a clean rerun
        mode = 0;
        test_id++;
        @(negedge clk);
        pulse_start();
        found = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (mem_bus.read && mem_bus.addr == 4'd5) begin
                found = 1'b1;
                break;
            end
        end
        check("rd5_seen", 32'(found), 1);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("abort");
        test_id++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_test(0, '0, '0, 1'b1);
        check("rerun_err", 32'(err_count), 0);
        check("rerun_timeout", 32'(timeout_err), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/crc_mem_bist.md
# crc_mem_bist

Self-test initiator for the CRC-protected faulty memory. It walks every address, writes a known pattern and reads it back, and counts words whose read fails the CRC check or the data compare. It runs two passes, pattern then inverted pattern, and reports pass/fail, an error count and the first failing location. It drives the memory's write/read command side, i.e. the role a bench plays today, so the memory can be exercised in-system.

## Interface
Parameters:
- ADDR_W, 4, memory address width (depth = 2**ADDR_W)
- DATA_W, 8, data word width
- SEED, 8'h5A, pattern base; expected word = addr-zero-extended XOR SEED (pass 1 inverted)
- TIMEOUT, 32, max cycles from command issue to mem_completed

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a test; ignored unless idle
- inj_fault_addr  in  ADDR_W  fault bit position forwarded on reads (only with macro)
- inj_burst_len  in  2  burst length code 0..3 = 1..4 bits (only with macro)
- busy  out  1  test in progress
- done  out  1  one-cycle pulse at test end
- pass  out  1  last test had zero errors and no timeout; held until next start
- err_count  out  6  failing reads, saturating at 63
- first_fail_addr  out  ADDR_W  address of first failing read
- first_fail_pass  out  1  pass index (0/1) of first failing read
- timeout_err  out  1  memory did not complete in TIMEOUT cycles
- mem_write, mem_read  out  1  one-cycle command strobes
- mem_addr  out  ADDR_W, mem_wdata  out  DATA_W
- mem_fault_addr  out  ADDR_W, mem_burst_len  out  2, mem_fault_enable  out  1
- mem_write_busy, mem_read_busy, mem_data_valid, mem_error_detected, mem_completed  in  1
- mem_rdata  in  DATA_W

## Operation
- States: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, NEXT, FINISH.
- IDLE + start: clear err_count, first_fail_*, timeout_err, pass. Set addr=0, pass_idx=0. Go to WR_ISSUE.
- WR_ISSUE: wait until both mem busy inputs are 0. Then pulse mem_write for one cycle with mem_addr=addr and mem_wdata=expected. Go to WR_WAIT.
- WR_WAIT: on mem_completed, if addr = max, set addr=0 and go to RD_ISSUE; otherwise addr+1 and go to WR_ISSUE.
- RD_ISSUE: same busy gating as WR_ISSUE. Pulse mem_read. Go to RD_WAIT.
- RD_WAIT: in the cycle mem_completed=1, sample the read result. The read fails if mem_error_detected=1, or mem_data_valid=0, or mem_rdata != expected.
  - On failure: err_count+1, saturating at 63.
  - On the first failure only: latch first_fail_addr and first_fail_pass.
  - Then go to NEXT.
- NEXT:
  - addr < max: addr+1, go to RD_ISSUE.
  - addr = max and pass_idx=0: pass_idx=1, addr=0, go to WR_ISSUE.
  - addr = max and pass_idx=1: go to FINISH.
- FINISH: pulse done, set pass = (err_count==0) and not timeout_err, go to IDLE.
- Timeout: a counter clears on each command issue. In WR_WAIT/RD_WAIT it increments each cycle without mem_completed. On reaching TIMEOUT: set timeout_err=1 and go to FINISH, which drives pass=0.
- mem_completed outside WR_WAIT/RD_WAIT is ignored.
- start while busy is ignored.
- rst_n low mid-test aborts immediately: all state returns to reset values and strobes drop the same cycle (asynchronously).

## Timing
- Reset values:
  - busy, done, pass, timeout_err, mem_write, mem_read, mem_fault_enable = 0
  - err_count, first_fail_*, mem_addr, mem_wdata, mem_fault_addr, mem_burst_len = 0
  - state = IDLE
- busy rises the cycle after start is sampled and falls in the same cycle done pulses.
- Command strobes are exactly one cycle wide. mem_addr, mem_wdata and mem_fault_* are stable from the strobe cycle until mem_completed.
- Issue latency: a command issues one cycle after entering an ISSUE state if the memory is not busy.
- Per-access overhead beyond memory latency: 2 cycles. Total test = 64 accesses.

## Configuration
- CRC_BIST_FAULT_INJ_EN defined:
  - on reads, mem_fault_enable=1 and mem_fault_addr/mem_burst_len are driven from inj_fault_addr/inj_burst_len, registered at start;
  - on writes, mem_fault_enable=0.
- Not defined: mem_fault_enable, mem_fault_addr and mem_burst_len are tied to 0, and the inj_* inputs are unused.

## Structure
- Shared package crc_mem_pkg holds:
  - the state enum;
  - ADDR_W/DATA_W defaults;
  - the err_count width;
  - the burst-length encoding constants.
- One sub-module, crc_bist_timeout: a loadable down-counter with a clear input and an expire output.
- Expected-pattern generation stays inline.

## Test plan
- Healthy memory model (completes 13 cycles after strobe), SEED=8'h5A, no macro -> done after 64 accesses, pass=1, err_count=0, timeout_err=0. Writes carry addr^8'h5A on pass 0 and its inversion on pass 1.
- Macro defined, inj_fault_addr=3, inj_burst_len=0 -> every read flags an error: err_count=32, pass=0, first_fail_addr=0, first_fail_pass=0.
- Macro defined, inj_burst_len=3 (4-bit burst) at bit 4 -> err_count=32 and mem_fault_enable seen only on read strobes.
- Memory model corrupts only address 9 on pass 1 (rdata off by one bit, CRC flag 0) -> err_count=1, first_fail_addr=9, first_fail_pass=1.
- Memory model never asserts mem_completed on the 5th write -> timeout_err=1 and done 32 cycles after that strobe, pass=0. A start pulsed during the test is ignored.
- rst_n asserted during RD_WAIT -> all outputs at reset values at once. A new start then yields a full clean run.
